alu_seq: RTL

Sequencing front-end for the combinational ALU. It accepts operation requests over a valid/ready handshake and drives the ALU operand and opcode inputs. It iterates multi-bit shifts as repeated 1-bit ALU shifts, registers the result and flags, and returns them over a valid/ready response handshake. It sits between the CPU control/decode logic and the ALU datapath.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequencer in front of a combinational ALU; iterates
//            multi-bit shifts as repeated 1-bit ALU shifts.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [3:0]       resp_flags,
    output logic             resp_err,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_exec  = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    localparam logic [3:0]       c_op_shln  = 4'd8;
    localparam logic [3:0]       c_op_shrn  = 4'd9;
    localparam logic [2:0]       c_alu_or   = 3'd3;
    localparam logic [2:0]       c_alu_shl1 = 3'd6;
    localparam logic [2:0]       c_alu_shr1 = 3'd7;
    localparam logic [WIDTH-1:0] c_width_b  = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  c_width_n  = CNTW'(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNTW-1:0]  r_count;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic [3:0]       r_resp_flags;
    logic             r_resp_err;

    logic             w_illegal;
    logic             w_is_shift;
    logic [CNTW-1:0]  w_shift_cnt;

    assign w_illegal   = (req_op > c_op_shrn);
    assign w_is_shift  = (req_op == c_op_shln) || (req_op == c_op_shrn);
    // Any count of WIDTH or more empties the operand, so clamp it there.
    assign w_shift_cnt = (req_b >= c_width_b) ? c_width_n : req_b[CNTW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (req_valid) begin
                    if (w_illegal)       w_state_next = c_resp;
                    else if (w_is_shift) w_state_next = c_shift;
                    else                 w_state_next = c_exec;
                end
            end
            c_exec:  w_state_next = c_resp;
            c_shift: begin
                if (r_count <= CNTW'(1)) w_state_next = c_resp;
            end
            c_resp: begin
                if (resp_ready) w_state_next = c_idle;
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        alu_op    = 3'd0;
        alu_a     = '0;
        alu_b     = '0;
        req_ready = (r_state == c_idle);
        busy      = (r_state != c_idle);
        case (r_state)
            c_exec: begin
                alu_op = r_op[2:0];
                alu_a  = r_a;
                alu_b  = r_b;
            end
            c_shift: begin
                // A zero count still makes one ALU pass so the flags describe a.
                if (r_count == '0) begin
                    alu_op = c_alu_or;
                    alu_a  = r_a;
                    alu_b  = r_a;
                end else begin
                    alu_op = (r_op == c_op_shrn) ? c_alu_shr1 : c_alu_shl1;
                    alu_a  = r_acc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_count      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_acc   <= req_a;
                        r_count <= w_shift_cnt;
                        if (w_illegal) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                            r_resp_flags <= '0;
                        end
                    end
                end
                c_exec: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= alu_result;
                    r_resp_flags <= alu_flags;
                end
                c_shift: begin
                    if (r_count != '0) begin
                        r_acc   <= alu_result;
                        r_count <= r_count - CNTW'(1);
                    end
                    if (r_count <= CNTW'(1)) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= alu_result;
                        r_resp_flags <= alu_flags;
                    end
                end
                c_resp: begin
                    if (resp_ready) r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_flags = r_resp_flags;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire
